// File: rtl/dand_soc_pkg.sv
// Shared types and constants for the DAND SoC banner/echo block.
package dand_soc_pkg;
  localparam int DEF_CLK_FREQ  = 30_000_000;
  localparam int DEF_BAUD_RATE = 921_600;
  localparam int BANNER_LEN    = 6;

  localparam logic [7:0] BANNER_B0 = 8'h44;  // 'D'
  localparam logic [7:0] BANNER_B1 = 8'h41;  // 'A'
  localparam logic [7:0] BANNER_B2 = 8'h4E;  // 'N'
  localparam logic [7:0] BANNER_B3 = 8'h44;  // 'D'
  localparam logic [7:0] BANNER_B4 = 8'h0D;
  localparam logic [7:0] BANNER_B5 = 8'h0A;

  typedef enum logic [1:0] {BANNER, ECHO_WAIT, ECHO_SEND} state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  function automatic logic [7:0] banner_byte(input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = BANNER_B0;
      3'd1:    b = BANNER_B1;
      3'd2:    b = BANNER_B2;
      3'd3:    b = BANNER_B3;
      3'd4:    b = BANNER_B4;
      3'd5:    b = BANNER_B5;
      default: b = 8'h00;
    endcase
    return b;
  endfunction
endpackage

// File: rtl/dand_uart.sv
// 8N1 UART: back-to-back capable transmitter and mid-bit sampling receiver.
// The receiver exists only when DAND_SOC_ECHO_EN is defined.
module dand_uart
  import dand_soc_pkg::*;
#(
  parameter int CLKS_PER_BIT = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  output logic       txd,
  input  logic       rxd,
  output logic       rx_valid,
  output logic [7:0] rx_data
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic          tx_busy, tx_last;
  logic [8:0]    tx_shift;
  logic [3:0]    tx_bit;
  logic [CW-1:0] tx_cnt;

  // Ready in the final stop-bit cycle so the next frame follows with no gap.
  assign tx_last  = tx_busy && (tx_bit == 4'd9) && (tx_cnt == BIT_LAST);
  assign tx_ready = !tx_busy || tx_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_busy  <= 1'b0;
      tx_shift <= '1;
      tx_bit   <= '0;
      tx_cnt   <= '0;
      txd      <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      tx_busy  <= 1'b1;
      tx_shift <= {1'b1, tx_data};
      tx_bit   <= '0;
      tx_cnt   <= '0;
      txd      <= 1'b0;
    end else if (tx_busy) begin
      if (tx_cnt == BIT_LAST) begin
        tx_cnt <= '0;
        if (tx_bit == 4'd9) begin
          tx_busy <= 1'b0;
          txd     <= 1'b1;
        end else begin
          txd      <= tx_shift[0];
          tx_shift <= {1'b1, tx_shift[8:1]};
          tx_bit   <= tx_bit + 1'b1;
        end
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

`ifdef DAND_SOC_ECHO_EN
  rx_state_t     rx_st, rx_nxt;
  logic          rx_s1, rx_s2, rx_prev, rx_tick;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;

  always_comb begin
    rx_nxt  = rx_st;
    rx_tick = 1'b0;
    unique case (rx_st)
      RX_IDLE:  if (rx_prev && !rx_s2) rx_nxt = RX_START;
      RX_START: if (rx_cnt == HALF_LAST) begin
        rx_tick = 1'b1;
        rx_nxt  = rx_s2 ? RX_IDLE : RX_DATA;  // high at mid-start: glitch
      end
      RX_DATA: if (rx_cnt == BIT_LAST) begin
        rx_tick = 1'b1;
        if (rx_bit == 3'd7) rx_nxt = RX_STOP;
      end
      RX_STOP: if (rx_cnt == BIT_LAST) begin
        rx_tick = 1'b1;
        rx_nxt  = RX_IDLE;
      end
      default: rx_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st    <= RX_IDLE;
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_st    <= rx_nxt;
      rx_s1    <= rxd;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_valid <= 1'b0;
      rx_cnt   <= (rx_st == RX_IDLE || rx_tick) ? '0 : rx_cnt + 1'b1;
      if (rx_tick) begin
        case (rx_st)
          RX_START: rx_bit <= '0;
          RX_DATA: begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_bit   <= rx_bit + 1'b1;
          end
          RX_STOP: rx_valid <= rx_s2;  // stop bit 0 drops the byte
          default: ;
        endcase
      end
    end
  end

  assign rx_data = rx_shift;
`else
  logic rxd_unused;
  assign rxd_unused = rxd;
  assign rx_valid   = 1'b0;
  assign rx_data    = 8'h00;
`endif
endmodule

// File: rtl/dand_soc_simple.sv
// Banner transmitter with optional UART echo through a small FIFO.
// Echo path (receiver, FIFO, echo states) is enabled by DAND_SOC_ECHO_EN.
module dand_soc_simple
  import dand_soc_pkg::*;
#(
  parameter int CLK_FREQ   = DEF_CLK_FREQ,
  parameter int BAUD_RATE  = DEF_BAUD_RATE,
  parameter int FIFO_DEPTH = 4
) (
  input  logic io_axiClk,
  input  logic io_reset,
  output logic io_uart_txd,
  input  logic io_uart_rxd
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam logic [2:0] BLEN = 3'(BANNER_LEN);

  state_t     st, st_nxt;
  logic [2:0] idx;
  logic       go;
  logic       tx_valid, tx_ready, rx_valid, pop, fifo_empty;
  logic [7:0] tx_data, rx_data, fifo_rd;

  dand_uart #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .clk      (io_axiClk),
    .rst      (io_reset),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .txd      (io_uart_txd),
    .rxd      (io_uart_rxd),
    .rx_valid (rx_valid),
    .rx_data  (rx_data)
  );

  always_comb begin
    st_nxt   = st;
    tx_valid = 1'b0;
    tx_data  = banner_byte(idx);
    pop      = 1'b0;
    unique case (st)
      BANNER: begin
        tx_valid = go && (idx < BLEN);
        if (idx == BLEN && tx_ready) st_nxt = ECHO_WAIT;
      end
      ECHO_WAIT: if (!fifo_empty) begin
        tx_valid = 1'b1;
        tx_data  = fifo_rd;
        if (tx_ready) begin
          pop    = 1'b1;
          st_nxt = ECHO_SEND;
        end
      end
      ECHO_SEND: if (tx_ready) st_nxt = ECHO_WAIT;
      default:   st_nxt = BANNER;
    endcase
  end

  // go delays the first banner request one cycle after reset release.
  always_ff @(posedge io_axiClk) begin
    if (io_reset) begin
      st  <= BANNER;
      idx <= '0;
      go  <= 1'b0;
    end else begin
      st <= st_nxt;
      go <= 1'b1;
      if (st == BANNER && tx_valid && tx_ready) idx <= idx + 3'd1;
    end
  end

`ifdef DAND_SOC_ECHO_EN
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [7:0] mem [FIFO_DEPTH];
  logic [PW:0] wr_ptr, rd_ptr;
  logic        full, push;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign push       = rx_valid && (!full || pop);
  assign fifo_rd    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge io_axiClk) begin
    if (io_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge io_axiClk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= rx_data;
  end
`else
  logic sink_unused;
  assign fifo_empty  = 1'b1;
  assign fifo_rd     = 8'h00;
  assign sink_unused = ^{rx_valid, rx_data, pop, FIFO_DEPTH[0]};
`endif
endmodule

// File: tb/tb_dand_soc_simple.sv
// Directed bench for dand_soc_simple: banner timing/content, echo path
// (when DAND_SOC_ECHO_EN is defined), frame errors, glitches and mid-frame reset.
module tb_dand_soc_simple;
  localparam int CPB = 30_000_000 / 921_600;
  localparam int FRM = 10 * CPB;

  logic clk = 1'b0, rst = 1'b1, rxd = 1'b1;
  logic txd;
  int   cyc = 0;
  int   n_chk = 0, n_pass = 0;

  logic [7:0] banner [6] = '{8'h44, 8'h41, 8'h4E, 8'h44, 8'h0D, 8'h0A};
  logic [7:0] burst  [5] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};

  logic [9:0] q  [$];
  int         qc [$];
  int         mon_t = -1, mon_start = 0;
  logic [9:0] mon_sh = '0;

  dand_soc_simple dut (
    .io_axiClk   (clk),
    .io_reset    (rst),
    .io_uart_txd (txd),
    .io_uart_rxd (rxd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // txd frame decoder: samples mid-bit, records start cycle and raw 10-bit frame.
  always @(negedge clk) begin
    if (rst) mon_t = -1;
    else if (mon_t < 0) begin
      if (txd === 1'b0) begin
        mon_t     = 0;
        mon_start = cyc;
      end
    end else begin
      mon_t++;
      if (mon_t % CPB == CPB / 2) begin
        mon_sh = {txd, mon_sh[9:1]};
        if (mon_t == CPB / 2 + 9 * CPB) begin
          q.push_back(mon_sh);
          qc.push_back(mon_start);
          mon_t = -1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, output int sc);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    sc = 0;
    for (int i = 0; i < 10; i++) begin
      rxd = fr[i];
      if (i == 9) sc = cyc;
      tick(CPB);
    end
  endtask

  task automatic get_frame(input string tag, input logic [7:0] eb, input int ec, output int c);
    int n;
    logic [9:0] v;
    n = 0;
    c = -1;
    while (q.size() == 0 && n < 2000) begin @(posedge clk); n++; end
    chk({tag, "_arrived"}, 32'(q.size() > 0), 1);
    if (q.size() > 0) begin
      v = q.pop_front();
      c = qc.pop_front();
      chk({tag, "_data"}, 32'(v), 32'({1'b1, eb, 1'b0}));
      if (ec >= 0) chk({tag, "_cyc"}, c, ec);
    end
  endtask

  int rel, c, sc, lows;

  initial begin
    tick(3);
    chk("rst_txd_early", txd, 1);
    wait_until(50);
    chk("rst_txd_late", txd, 1);
    chk("rst_no_frames", q.size(), 0);
    rst = 1'b0;
    rel = cyc;

    // Five bytes arrive during the banner; FIFO holds four.
    fork
      begin
        int d;
        tick(3);
        for (int i = 0; i < 5; i++) send_byte(burst[i], 1'b1, d);
      end
    join_none

    for (int k = 0; k < 6; k++)
      get_frame($sformatf("banner%0d", k), banner[k], rel + 2 + FRM * k, c);
`ifdef DAND_SOC_ECHO_EN
    for (int k = 0; k < 4; k++)
      get_frame($sformatf("echo%0d", k), burst[k], rel + 2 + 6 * FRM + 1 + (FRM + 1) * k, c);
`endif
    tick(600);
    chk("no_extra_frames", q.size(), 0);
    chk("idle_txd", txd, 1);

    send_byte(8'h5A, 1'b1, sc);
`ifdef DAND_SOC_ECHO_EN
    get_frame("echo5a", 8'h5A, -1, c);
    chk("echo5a_latency_ok", 32'(c >= sc + 18 && c <= sc + 22), 1);
`endif
    tick(400);
    chk("after5a_empty", q.size(), 0);

    // Stop bit 0 must be discarded; the following good byte still goes through.
    send_byte(8'h55, 1'b0, sc);
    rxd = 1'b1;
    tick(40);
    send_byte(8'h7E, 1'b1, sc);
`ifdef DAND_SOC_ECHO_EN
    get_frame("ferr_7e", 8'h7E, -1, c);
`endif
    tick(400);
    chk("ferr_only_one", q.size(), 0);

    rxd = 1'b0;
    tick(5);
    rxd = 1'b1;
    lows = 0;
    for (int i = 0; i < 400; i++) begin
      tick(1);
      if (txd !== 1'b1) lows++;
    end
    chk("glitch_txd_idle", lows, 0);
    chk("glitch_no_frame", q.size(), 0);

    rst = 1'b1;
    tick(3);
    chk("rst2_txd", txd, 1);
    rst = 1'b0;
    rel = cyc;
    get_frame("rb0", 8'h44, rel + 2, c);
    get_frame("rb1", 8'h41, rel + 2 + FRM, c);
    // 40 cycles into byte 2 (0x4E) txd carries data bit 0, which is 0.
    wait_until(rel + 2 + 2 * FRM + 40);
    chk("abort_pre_txd", txd, 0);
    rst = 1'b1;
    tick(1);
    chk("abort_txd", txd, 1);
    tick(5);
    chk("abort_hold_txd", txd, 1);
    rst = 1'b0;
    rel = cyc;
    get_frame("restart0", 8'h44, rel + 2, c);
    get_frame("restart1", 8'h41, rel + 2 + FRM, c);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
